inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
Parametrised multi-lane instruction queue between IF and ID, replacing the IF/ID pipeline register. It accepts up to IN_W fetched instructions per cycle and presents up to OUT_W in-order instructions per cycle to decode. It is a circular buffer with explicit valid tracking and occupancy count. Payload is never used as an empty marker, so an all-zero instruction/PC is legal.

Parameters:
DEPTH, 8, entry count; power of two, >= 2*max(IN_W,OUT_W)
IN_W, 2, enqueue lanes per cycle
OUT_W, 2, dequeue lanes per cycle
INST_W, 32, instruction width
PC_W, 32, pc/npc width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  branch mispredict; discard all entries
in_valid  in  IN_W  per-lane enqueue valid; holes allowed
in_inst  in  IN_W*INST_W  lane i at [i*INST_W +: INST_W]
in_pc  in  IN_W*PC_W  lane pc
in_npc  in  IN_W*PC_W  lane predicted next pc
in_ready  out  1  queue can take a full IN_W group this cycle
out_valid  out  OUT_W  thermometer: lane k valid iff k < count
out_inst  out  OUT_W*INST_W  entry head+k
out_pc  out  OUT_W*PC_W  pc of entry head+k
out_npc  out  OUT_W*PC_W  npc of entry head+k
deq_num  in  clog2(OUT_W+1)  entries consumed by ID this cycle
count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- State: head, tail pointers (clog2(DEPTH) bits, wrap modulo DEPTH); count register; storage array of {pc,npc,inst}. Storage is not reset.
- Reset (rst=1 at posedge): head=0, tail=0, count=0. Then out_valid=0, in_ready=1, count=0. Reset overrides flush and all traffic.
- in_ready = (DEPTH - count) >= IN_W. Combinational from registered count only; no same-cycle dequeue credit, so there is no in_ready->deq_num path.
- Enqueue fires when in_ready=1 and in_valid != 0. Valid lanes are compacted in ascending lane order into tail, tail+1, ... Example: in_valid=2'b10 writes only lane 1 to tail. tail += popcount(in_valid).
- With in_ready=0, in_valid is ignored. IF must hold the group itself. No partial acceptance.
- Dequeue: effective d = min(deq_num, count, OUT_W). Over-request is clipped, not an error. head += d.
- count_next = count + enq_n - d. Same-cycle enqueue and dequeue are both applied.
- Outputs are show-ahead and combinational from storage/head/count. A written entry appears on out_* the cycle after its enqueue edge (1-cycle latency).
- out_* payload on invalid lanes is don't-care. Bench checks payload only where out_valid=1.
- flush=1 at posedge: head=tail=0, count=0, and same-cycle enqueue and dequeue are discarded. The next cycle has out_valid=0 and in_ready=1.
- Full: count==DEPTH leaves in_ready=0 with dequeue still allowed. Empty: out_valid=0, and deq_num is clipped to 0.
- Pointer wrap: a group straddling DEPTH-1 -> 0 is written and read contiguously modulo DEPTH.

Decomposition:
- Shared package/def header: INST_W, PC_W, entry struct/concat layout {pc,npc,inst}, clog2 helper function.
- One sub-module, inst_queue_compact: combinational lane compaction of in_valid. It yields per-output-slot source lane index, slot valid, and popcount. It is reusable by the issue stage.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0. Enqueue {pc=0,npc=4,inst=0} -> next cycle out_valid[0]=1, pc=0 (zero payload is a valid entry).
- Enqueue pc 0x100,0x104 each cycle with deq_num=0 (DEPTH=8) -> count 2,4,6; in_ready=0 at count 7 or 8 (forced via single-lane enqueue 2'b01); no overwrite.
- in_valid=2'b10 (pc 0x204 on lane 1), queue empty -> next cycle out_pc lane0=0x204, out_valid=2'b01, count=1.
- count=6, enqueue 2 and deq_num=2 same cycle -> count stays 6; out lane0 shows former entry head+2.
- Fill to 5, deq_num=2 three times -> d=2,2,1 (clipped); count 3,1,0; head wraps past index 7 with correct order 0x100.. preserved.
- count=5 with flush=1 and in_valid=2'b11 same cycle -> next cycle count=0, out_valid=0, in_ready=1. Flush and rst together -> reset result.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue.
// Default widths, entry layout and constant helpers.
package inst_queue_pkg;

    localparam int DEF_INST_W = 32;
    localparam int DEF_PC_W   = 32;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_PC_W-1:0]   npc;
        logic [DEF_INST_W-1:0] inst;
    } iq_entry_t;

    function automatic int iq_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int iq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/inst_queue_compact.sv
// Packs the set lanes of a valid vector into leading slots.
// Slot s takes the lane whose count of lower valid lanes is s.
module inst_queue_compact
    import inst_queue_pkg::*;
#(
    parameter int IN_W = 2,
    parameter int LW   = iq_max(1, iq_clog2(IN_W)),
    parameter int CW   = iq_clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]         valid,
    output logic [IN_W-1:0][LW-1:0] slot_src,
    output logic [IN_W-1:0]         slot_vld,
    output logic [CW-1:0]           pop
);

    logic [IN_W-1:0][CW-1:0] pre;
    logic [CW-1:0]           run;

    always_comb begin
        pre = '0;
        run = '0;
        for (int i = 0; i < IN_W; i++) begin
            pre[i] = run;
            run    = run + CW'(valid[i]);
        end
        pop = run;
    end

    always_comb begin
        slot_src = '0;
        slot_vld = '0;
        for (int s = 0; s < IN_W; s++) begin
            for (int i = 0; i < IN_W; i++) begin
                if (valid[i] && pre[i] == CW'(s)) begin
                    slot_vld[s] = 1'b1;
                    slot_src[s] = LW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane circular instruction queue between fetch and decode.
// Show-ahead outputs; occupancy is tracked explicitly, not by payload.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2,
    parameter int INST_W = DEF_INST_W,
    parameter int PC_W   = DEF_PC_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [IN_W-1:0]                 in_valid,
    input  logic [IN_W*INST_W-1:0]          in_inst,
    input  logic [IN_W*PC_W-1:0]            in_pc,
    input  logic [IN_W*PC_W-1:0]            in_npc,
    output logic                            in_ready,
    output logic [OUT_W-1:0]                out_valid,
    output logic [OUT_W*INST_W-1:0]         out_inst,
    output logic [OUT_W*PC_W-1:0]           out_pc,
    output logic [OUT_W*PC_W-1:0]           out_npc,
    input  logic [iq_clog2(OUT_W+1)-1:0]    deq_num,
    output logic [iq_clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = iq_clog2(DEPTH);
    localparam int CNT_W = iq_clog2(DEPTH + 1);
    localparam int LW    = iq_max(1, iq_clog2(IN_W));
    localparam int CW    = iq_clog2(IN_W + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t mem [DEPTH];

    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [IN_W-1:0][LW-1:0]  slot_src;
    logic [IN_W-1:0]          slot_vld;
    logic [CW-1:0]            pop;
    logic                     enq;
    logic                     wr_en;
    logic [CNT_W-1:0]         enq_n;
    logic [CNT_W-1:0]         deq_n;
    ent_t                     lane_ent [IN_W];

    inst_queue_compact #(
        .IN_W (IN_W)
    ) u_compact (
        .valid    (in_valid),
        .slot_src (slot_src),
        .slot_vld (slot_vld),
        .pop      (pop)
    );

    // No dequeue credit: ready depends on registered count only.
    assign in_ready = count <= CNT_W'(DEPTH - IN_W);
    assign enq      = in_ready & (|in_valid);
    assign wr_en    = enq & ~flush & ~rst;
    assign enq_n    = enq ? CNT_W'(pop) : '0;

    always_comb begin
        deq_n = CNT_W'(deq_num);
        if (deq_n > count)
            deq_n = count;
        if (deq_n > CNT_W'(OUT_W))
            deq_n = CNT_W'(OUT_W);
    end

    always_comb begin
        for (int i = 0; i < IN_W; i++) begin
            lane_ent[i].pc   = in_pc[i*PC_W +: PC_W];
            lane_ent[i].npc  = in_npc[i*PC_W +: PC_W];
            lane_ent[i].inst = in_inst[i*INST_W +: INST_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int s = 0; s < IN_W; s++) begin
                if (slot_vld[s])
                    mem[tail + PTR_W'(s)] <= lane_ent[slot_src[s]];
            end
        end
    end

    always_comb begin
        ent_t e;
        e         = '0;
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        out_npc   = '0;
        for (int k = 0; k < OUT_W; k++) begin
            e                           = mem[head + PTR_W'(k)];
            out_valid[k]                = count > CNT_W'(k);
            out_inst[k*INST_W +: INST_W] = e.inst;
            out_pc[k*PC_W +: PC_W]       = e.pc;
            out_npc[k*PC_W +: PC_W]      = e.npc;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed bench for inst_queue.
// Reference model is a plain queue of entries.
module tb_inst_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] in_npc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [63:0] out_npc;
    logic [1:0]  deq_num;
    logic [3:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   errors;
    int   checks;

    inst_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_npc    (in_npc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_npc   (out_npc),
        .deq_num   (deq_num),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc * 32'h9e37_79b9;
    endfunction

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'((8 - n) >= 2));
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", 64'(out_valid[k]), 64'(k < n));
            if (k < n) begin
                chk("out_pc", 64'(out_pc[k*32 +: 32]), 64'(q[k].pc));
                chk("out_npc", 64'(out_npc[k*32 +: 32]), 64'(q[k].npc));
                chk("out_inst", 64'(out_inst[k*32 +: 32]), 64'(q[k].inst));
            end
        end
    endtask

    task automatic drive(input logic r, input logic f,
                         input logic [1:0] v,
                         input logic [31:0] pc0,
                         input logic [31:0] pc1,
                         input logic [1:0] dq);
        ent_t e [2];
        int   d;
        bit   rdy;
        e[0] = '{pc: pc0, npc: pc0 + 32'd4, inst: inst_of(pc0)};
        e[1] = '{pc: pc1, npc: pc1 + 32'd4, inst: inst_of(pc1)};
        rst      = r;
        flush    = f;
        in_valid = v;
        deq_num  = dq;
        in_pc    = {e[1].pc, e[0].pc};
        in_npc   = {e[1].npc, e[0].npc};
        in_inst  = {e[1].inst, e[0].inst};
        #2;
        check_outputs();
        rdy = (8 - q.size()) >= 2;
        @(posedge clk);
        if (r || f) begin
            q.delete();
        end else begin
            d = int'(dq);
            if (d > q.size()) d = q.size();
            if (d > 2) d = 2;
            repeat (d) void'(q.pop_front());
            if (rdy) begin
                for (int i = 0; i < 2; i++)
                    if (v[i]) q.push_back(e[i]);
            end
        end
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = '0;
        in_inst  = '0;
        in_pc    = '0;
        in_npc   = '0;
        deq_num  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);

        // idle, then an all-zero pc/inst entry
        drive(0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 2'b01, 32'h0, 32'h0, 0);
        drive(0, 0, 2'b00, 0, 0, 0);

        // fill with pairs, single lane, then blocked group
        drive(0, 1, 2'b00, 0, 0, 0);
        drive(0, 0, 2'b11, 32'h100, 32'h104, 0);
        drive(0, 0, 2'b11, 32'h108, 32'h10c, 0);
        drive(0, 0, 2'b11, 32'h110, 32'h114, 0);
        drive(0, 0, 2'b01, 32'h118, 32'h11c, 0);
        drive(0, 0, 2'b11, 32'h120, 32'h124, 0);
        drive(0, 0, 2'b11, 32'h128, 32'h12c, 0);

        // upper lane only into an empty queue
        drive(0, 1, 2'b00, 0, 0, 0);
        drive(0, 0, 2'b10, 32'h200, 32'h204, 0);
        drive(0, 0, 2'b00, 0, 0, 0);

        // count=6 with simultaneous enqueue/dequeue
        drive(0, 1, 2'b00, 0, 0, 0);
        drive(0, 0, 2'b11, 32'h100, 32'h104, 0);
        drive(0, 0, 2'b11, 32'h108, 32'h10c, 0);
        drive(0, 0, 2'b11, 32'h110, 32'h114, 0);
        drive(0, 0, 2'b11, 32'h118, 32'h11c, 2);
        drive(0, 0, 2'b00, 0, 0, 1);

        // clipped dequeues, head wraps past index 7
        drive(0, 0, 2'b00, 0, 0, 2);
        drive(0, 0, 2'b00, 0, 0, 2);
        drive(0, 0, 2'b00, 0, 0, 2);
        drive(0, 0, 2'b00, 0, 0, 3);

        // flush with traffic, then flush with reset
        drive(0, 0, 2'b11, 32'h300, 32'h304, 0);
        drive(0, 0, 2'b11, 32'h308, 32'h30c, 0);
        drive(0, 0, 2'b01, 32'h310, 32'h314, 0);
        drive(0, 1, 2'b11, 32'h318, 32'h31c, 2);
        drive(0, 0, 2'b11, 32'h400, 32'h404, 0);
        drive(1, 1, 2'b11, 32'h408, 32'h40c, 1);
        drive(0, 0, 2'b00, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            logic r;
            logic f;
            r = ($urandom_range(0, 299) == 0);
            f = ($urandom_range(0, 39) == 0);
            drive(r, f, 2'($urandom_range(0, 3)),
                  $urandom, $urandom,
                  2'($urandom_range(0, 3)));
        end
        drive(0, 0, 2'b00, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
